seq_booth_multiplier: RTL



---
 rtl/seq_booth_multiplier.sv | 115 +++++++++++
 1 files changed

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-2 Booth multiplier, signed or unsigned operands.
// One WIDTH x WIDTH product per WIDTH+1 compute steps, with in/out handshakes.
module seq_booth_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 SIGNED_MODE,
  input  logic [WIDTH-1:0]     SRC_A,
  input  logic [WIDTH-1:0]     SRC_B,
  output logic                 START_READY,
  output logic                 READYO,
  output logic [2*WIDTH-1:0]   PRODUCT,
  input  logic                 DEST_READY
);

  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH:0]     m;
  logic [WIDTH:0]     acc;
  logic [WIDTH:0]     q;
  logic               q_m1;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] product;

  logic [WIDTH:0]     m_ld;
  logic [WIDTH:0]     q_ld;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH+2:0] shf;
  logic [WIDTH:0]     acc_n;
  logic [WIDTH:0]     q_n;
  logic               qm1_n;

  // Extending to WIDTH+1 bits lets one signed Booth datapath serve both modes
  assign m_ld = {SIGNED_MODE & SRC_A[WIDTH-1], SRC_A};
  assign q_ld = {SIGNED_MODE & SRC_B[WIDTH-1], SRC_B};

  assign START_READY = (state == IDLE) | ((state == DONE) & DEST_READY);
  assign READYO      = (state == DONE);
  assign PRODUCT     = product;

  // One Booth step: add/sub on {Q[0], q_m1}, then arithmetic shift right
  always_comb begin
    unique case ({q[0], q_m1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
    shf = {sum[WIDTH], sum, q};
  end

  assign acc_n = shf[2*WIDTH+2:WIDTH+2];
  assign q_n   = shf[WIDTH+1:1];
  assign qm1_n = shf[0];

  // Control FSM and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (START) begin
            state <= CALC;
            m     <= m_ld;
            q     <= q_ld;
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
          end
        end
        CALC: begin
          acc  <= acc_n;
          q    <= q_n;
          q_m1 <= qm1_n;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH)) begin
            state   <= DONE;
            product <= shf[2*WIDTH:1];
          end
        end
        DONE: begin
          if (DEST_READY) begin
            if (START) begin
              state <= CALC;
              m     <= m_ld;
              q     <= q_ld;
              acc   <= '0;
              q_m1  <= 1'b0;
              cnt   <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
